// File: rtl/thymesisflow_credit_tx_gate_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : thymesisflow_credit_tx_gate_if
//  Description : Upstream flit handshake bundle feeding the credit TX gate.
//                The master drives valid/data and the slave returns ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface thymesisflow_credit_tx_gate_if #(
    parameter int DATA_W = 64
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    // Producer side of the handshake
    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    // Consumer side of the handshake (the TX gate)
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface
`default_nettype wire

// File: rtl/thymesisflow_credit_tx_gate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : thymesisflow_credit_tx_gate
//  Description : Credit-gated transmit stage. Buffers outbound flits in a
//                small FIFO and releases at most one per cycle while the
//                downstream credit manager reports credits. Drives the
//                manager's consume/reset inputs, supports a discard flush,
//                a sticky error state and a saturating credit-stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module thymesisflow_credit_tx_gate #(
    parameter int DATA_W     = 64,
    parameter int FIFO_AW    = 3,
    parameter int CREDIT_MSB = 2,
    parameter int STALL_W    = 16
) (
    input  logic                  clock,
    input  logic                  resetn,

    // upstream flit handshake (s_valid / s_ready / s_data)
    thymesisflow_credit_tx_gate_if.slave up,

    // credit manager side
    input  logic [CREDIT_MSB:0]   credits_available,
    input  logic                  credit_err,
    output logic                  consume_credit,
    output logic                  credit_reset,

    // control
    input  logic                  flush,
    input  logic                  stall_clr,

    // link side
    output logic                  tx_valid,
    output logic [DATA_W-1:0]     tx_data,

    // status
    output logic                  err,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 flush_done;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;

    logic                 empty;
    logic                 full;
    logic                 has_credit;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 stall;

    // ------------------------------------------------------------------
    // Occupancy flags and handshake / issue decisions
    // ------------------------------------------------------------------
    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign has_credit = (credits_available != '0);

    // No pass-through: a full FIFO refuses a push even when it pops.
    assign up.s_ready = (state == ST_RUN) && !full;
    assign push       = up.s_valid && up.s_ready;

    // The manager updates on the same edge, so credits_available is
    // always current and one consume per cycle can never underflow it.
    assign issue      = (state == ST_RUN) && !empty && has_credit;

    // Flushing drains one entry per cycle without spending a credit.
    assign pop        = issue || ((state == ST_FLUSH) && !empty);

    assign consume_credit = issue;
    assign err            = (state == ST_ERROR);
    assign stall          = (state == ST_RUN) && !empty && !has_credit;

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a credit error wins over any flush request
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            ST_RUN: begin
                if (credit_err) begin
                    state_nxt = ST_ERROR;
                end else if (flush) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (credit_err) begin
                    state_nxt = ST_ERROR;
                end else if (empty) begin
                    state_nxt  = ST_RUN;
                    flush_done = 1'b1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= up.s_data;
        end
    end

    // Link output register: valid for one cycle after each issue, data held
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= issue;
            if (issue) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    // One-cycle credit reload pulse when a flush has drained the FIFO.
    // Not raised by resetn: the manager shares that reset already.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            credit_reset <= 1'b0;
        end else begin
            credit_reset <= flush_done;
        end
    end

    // Saturating credit-stall counter; clear has priority over increment
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_thymesisflow_credit_tx_gate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_thymesisflow_credit_tx_gate
//  Description : Self-checking bench for the credit-gated TX stage with a
//                behavioural credit manager and an in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thymesisflow_credit_tx_gate;

    localparam int DATA_W     = 64;
    localparam int FIFO_AW    = 3;
    localparam int CREDIT_MSB = 2;
    localparam int STALL_W    = 4;

    logic                  clock = 1'b0;
    logic                  resetn = 1'b0;
    logic [CREDIT_MSB:0]   credits_available;
    logic [CREDIT_MSB:0]   init_credits = '0;
    logic                  ret_credit = 1'b0;
    logic                  credit_err = 1'b0;
    logic                  consume_credit;
    logic                  credit_reset;
    logic                  flush = 1'b0;
    logic                  stall_clr = 1'b0;
    logic                  tx_valid;
    logic [DATA_W-1:0]     tx_data;
    logic                  err;
    logic [STALL_W-1:0]    stall_cnt;

    thymesisflow_credit_tx_gate_if #(.DATA_W(DATA_W)) up_if ();

    thymesisflow_credit_tx_gate #(
        .DATA_W     (DATA_W),
        .FIFO_AW    (FIFO_AW),
        .CREDIT_MSB (CREDIT_MSB),
        .STALL_W    (STALL_W)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .up                (up_if.slave),
        .credits_available (credits_available),
        .credit_err        (credit_err),
        .consume_credit    (consume_credit),
        .credit_reset      (credit_reset),
        .flush             (flush),
        .stall_clr         (stall_clr),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .err               (err),
        .stall_cnt         (stall_cnt)
    );

    always #5 clock = ~clock;

    // Behavioural credit manager: reloads on reset or credit_reset
    always @(posedge clock) begin
        if (!resetn || credit_reset) begin
            credits_available <= init_credits;
        end else begin
            credits_available <= credits_available - 3'(consume_credit) + 3'(ret_credit);
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    int          push_cnt  = 0;
    int          issue_cnt = 0;
    int          tx_cnt    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Scoreboard: record accepted pushes, compare every emitted flit
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (tx_valid) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 64'd1, 64'd0);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
            end
            if (consume_credit) begin
                issue_cnt++;
            end
            if (up_if.s_valid && up_if.s_ready) begin
                exp_q.push_back(up_if.s_data);
                push_cnt++;
            end
            if (flush) begin
                exp_q.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int credits);
        init_credits    = 3'(credits);
        resetn          = 1'b0;
        up_if.s_valid   = 1'b0;
        up_if.s_data    = '0;
        flush           = 1'b0;
        stall_clr       = 1'b0;
        credit_err      = 1'b0;
        ret_credit      = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clock);
        check("rst_s_ready",  64'(up_if.s_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data",  tx_data, 64'd0);
        check("rst_err",      64'(err), 64'd0);
        check("rst_stall",    64'(stall_cnt), 64'd0);
        check("rst_creset",   64'(credit_reset), 64'd0);
        tick();
    endtask

    task automatic push(input logic [63:0] d);
        up_if.s_valid = 1'b1;
        up_if.s_data  = d;
        for (int i = 0; i < 64 && !up_if.s_ready; i++) tick();
        if (!up_if.s_ready) check("push_timeout", 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi, bt, bp, s1, s2, lo, pulses, cc, tv, er;

        // ---- basic flow and latency ----
        do_reset(4);
        bi = issue_cnt; bt = tx_cnt;
        up_if.s_valid = 1'b1; up_if.s_data = 64'hA;
        @(negedge clock); check("t1_c0_consume", 64'(consume_credit), 64'd0);
        tick(); up_if.s_data = 64'hB;
        @(negedge clock); check("t1_c1_consume", 64'(consume_credit), 64'd1);
        check("t1_c1_txv", 64'(tx_valid), 64'd0);
        tick(); up_if.s_data = 64'hC;
        @(negedge clock); check("t1_c2_consume", 64'(consume_credit), 64'd1);
        check("t1_c2_txv", 64'(tx_valid), 64'd1);
        tick(); up_if.s_valid = 1'b0;
        @(negedge clock); check("t1_c3_consume", 64'(consume_credit), 64'd1);
        tick();
        @(negedge clock); check("t1_c4_consume", 64'(consume_credit), 64'd0);
        check("t1_c4_txv", 64'(tx_valid), 64'd1);
        tick();
        @(negedge clock); check("t1_c5_txv", 64'(tx_valid), 64'd0);
        check("t1_issues", 64'(issue_cnt - bi), 64'd3);
        check("t1_txs", 64'(tx_cnt - bt), 64'd3);
        check("t1_stall", 64'(stall_cnt), 64'd0);
        tick();

        // ---- credit starvation ----
        do_reset(2);
        bi = issue_cnt; bt = tx_cnt;
        for (int i = 0; i < 5; i++) push(64'h200 + 64'(i));
        up_if.s_valid = 1'b0;
        repeat (4) tick();
        check("t2_issues", 64'(issue_cnt - bi), 64'd2);
        check("t2_txs", 64'(tx_cnt - bt), 64'd2);
        @(negedge clock); s1 = int'(stall_cnt);
        repeat (5) tick();
        @(negedge clock); s2 = int'(stall_cnt);
        check("t2_stall_delta", 64'(s2 - s1), 64'd5);
        tick();
        ret_credit = 1'b1; tick(); ret_credit = 1'b0;
        repeat (4) tick();
        check("t2_issues_after_ret", 64'(issue_cnt - bi), 64'd3);
        check("t2_txs_after_ret", 64'(tx_cnt - bt), 64'd3);
        check("t2_held", 64'(exp_q.size()), 64'd2);

        // ---- full FIFO ----
        do_reset(0);
        bp = push_cnt; bt = tx_cnt;
        for (int i = 0; i < 12; i++) begin
            up_if.s_valid = 1'b1;
            up_if.s_data  = 64'h300 + 64'(push_cnt - bp);
            tick();
        end
        check("t3_accepted", 64'(push_cnt - bp), 64'd8);
        check("t3_full_ready", 64'(up_if.s_ready), 64'd0);
        up_if.s_valid = 1'b0;
        ret_credit = 1'b1;
        @(negedge clock); check("t3_no_issue", 64'(consume_credit), 64'd0);
        tick();
        @(negedge clock); check("t3_first_pop", 64'(consume_credit), 64'd1);
        check("t3_ready_at_pop", 64'(up_if.s_ready), 64'd0);
        tick();
        @(negedge clock); check("t3_ready_after_pop", 64'(up_if.s_ready), 64'd1);
        repeat (6) tick();
        ret_credit = 1'b0;
        repeat (5) tick();
        check("t3_txs", 64'(tx_cnt - bt), 64'd8);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // ---- flush ----
        do_reset(3);
        bi = issue_cnt;
        for (int i = 0; i < 8; i++) push(64'h400 + 64'(i));
        up_if.s_valid = 1'b0;
        repeat (4) tick();
        check("t4_issues", 64'(issue_cnt - bi), 64'd3);
        check("t4_buffered", 64'(exp_q.size()), 64'd5);
        bi = issue_cnt; bt = tx_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        lo = 0; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (!up_if.s_ready) lo++;
            if (credit_reset) pulses++;
            tick();
        end
        check("t4_ready_low", 64'(lo), 64'd6);
        check("t4_creset_pulses", 64'(pulses), 64'd1);
        check("t4_no_issue", 64'(issue_cnt - bi), 64'd0);
        check("t4_no_tx", 64'(tx_cnt - bt), 64'd0);
        check("t4_credits_reloaded", 64'(credits_available), 64'd3);
        push(64'h4AA);
        up_if.s_valid = 1'b0;
        repeat (4) tick();
        check("t4_fresh_tx", 64'(tx_cnt - bt), 64'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (credit_reset) pulses++;
            tick();
        end
        check("t4_empty_flush_pulse", 64'(pulses), 64'd1);
        check("t4_empty_flush_credits", 64'(credits_available), 64'd3);

        // ---- sticky error ----
        do_reset(0);
        for (int i = 0; i < 3; i++) push(64'h500 + 64'(i));
        up_if.s_valid = 1'b0;
        tick();
        credit_err = 1'b1; tick(); credit_err = 1'b0;
        ret_credit = 1'b1; repeat (3) tick(); ret_credit = 1'b0;
        cc = 0; tv = 0; er = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (consume_credit) cc++;
            if (tx_valid) tv++;
            if (err && !up_if.s_ready) er++;
            tick();
        end
        check("t5_no_consume", 64'(cc), 64'd0);
        check("t5_no_tx", 64'(tv), 64'd0);
        check("t5_err_sticky", 64'(er), 64'd8);
        check("t5_credits_unspent", 64'(credits_available), 64'd3);

        // ---- stall counter saturation and clear priority ----
        do_reset(0);
        push(64'h600);
        up_if.s_valid = 1'b0;
        repeat (20) tick();
        @(negedge clock); check("t6_saturate", 64'(stall_cnt), 64'd15);
        tick();
        stall_clr = 1'b1; tick(); stall_clr = 1'b0;
        @(negedge clock); check("t6_clr", 64'(stall_cnt), 64'd0);
        tick();
        @(negedge clock); check("t6_resume", 64'(stall_cnt), 64'd1);
        tick();

        // ---- reset with a stalled flit, then clean traffic ----
        do_reset(2);
        bt = tx_cnt;
        push(64'h700); push(64'h701);
        up_if.s_valid = 1'b0;
        repeat (4) tick();
        check("t7_txs", 64'(tx_cnt - bt), 64'd2);
        check("t7_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
